// File: rtl/spi_regfile_burst.sv
// rtl/spi_regfile_burst.sv - SPI mode-0 slave register file with optional auto-increment bursts
// Frame: command bit, ADDR_WIDTH address bits, then one or more DATA_WIDTH words, all MSB first.
module spi_regfile_burst #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int RESET_VALUE = 0,
    parameter int AUTO_INC    = 1
) (
    input  logic                           SCLK,
    input  logic                           rst_n,
    input  logic                           nCS,
    input  logic                           COPI,
    output logic                           cipo,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic                           wr_strobe,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic                           addr_err,
    output logic                           busy
);

    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW);
    localparam logic [CW-1:0]         ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0]         DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   NREGS     = (ADDR_WIDTH + 1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] RST_VAL   = DATA_WIDTH'(RESET_VALUE);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                  state;
    logic                    cmd_wr;
    logic [SW-2:0]           shift;
    logic [CW-1:0]           bit_cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   tx_sr;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [SW-1:0]           next_shift;
    logic [ADDR_WIDTH-1:0]   addr_in;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [ADDR_WIDTH-1:0]   addr_inc;

    assign next_shift = {shift, COPI};
    assign addr_in    = next_shift[ADDR_WIDTH-1:0];
    assign data_in    = next_shift[DATA_WIDTH-1:0];
    assign addr_inc   = (addr == TOP_ADDR) ? '0 : addr + 1'b1;
    assign busy       = (state != IDLE);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    // Out-of-range addresses read as zero rather than aliasing onto a real register.
    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (a == ADDR_WIDTH'(i)) r = regs[i];
        end
        return r;
    endfunction

    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_wr    <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            tx_sr     <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            addr_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
        end else begin
            wr_strobe <= 1'b0;
            if (nCS) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tx_sr   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cmd_wr  <= COPI;
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end
                    ADDR: begin
                        shift <= next_shift[SW-2:0];
                        if (bit_cnt == ADDR_LAST) begin
                            addr    <= addr_in;
                            bit_cnt <= '0;
                            state   <= DATA;
                            tx_sr   <= (!cmd_wr && in_range(addr_in)) ? read_reg(addr_in) : '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        shift <= next_shift[SW-2:0];
                        tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (!in_range(addr)) begin
                                addr_err <= 1'b1;
                            end else if (cmd_wr) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (addr == ADDR_WIDTH'(i)) regs[i] <= data_in;
                                end
                                wr_addr   <= addr;
                                wr_strobe <= 1'b1;
                            end
                            // Reload at the same edge so the next word follows with no dead bit.
                            if (AUTO_INC != 0) begin
                                addr  <= addr_inc;
                                tx_sr <= (!cmd_wr && in_range(addr_inc)) ? read_reg(addr_inc) : '0;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    DONE:    state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(negedge SCLK) begin
        if (!rst_n) cipo <= 1'b0;
        else        cipo <= (state == DATA) && !cmd_wr && tx_sr[DATA_WIDTH-1];
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_spi_regfile_burst.sv
// tb/tb_spi_regfile_burst.sv - directed self-checking bench for spi_regfile_burst
module tb_spi_regfile_burst;

    logic        SCLK;
    logic        rst_n;
    logic        nCS;
    logic        COPI;
    logic        cipo;
    logic [39:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        addr_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int strobe_total = 0;
    int s0;
    logic       last_busy;
    logic [7:0] tx_words [4];
    logic [7:0] rx_words [4];

    spi_regfile_burst dut (
        .SCLK      (SCLK),
        .rst_n     (rst_n),
        .nCS       (nCS),
        .COPI      (COPI),
        .cipo      (cipo),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .addr_err  (addr_err),
        .busy      (busy)
    );

    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    always @(negedge SCLK) begin
        if (wr_strobe === 1'b1) strobe_total++;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller drives on the falling edge; results are read just after the rising edge.
    task automatic bit_cycle(input logic copi_v, input logic ncs_v);
        @(negedge SCLK);
        COPI = copi_v;
        nCS  = ncs_v;
        @(posedge SCLK);
        #1;
    endtask

    task automatic frame(input logic cmd, input logic [6:0] a, input int nbits);
        for (int i = 0; i < 4; i++) rx_words[i] = 8'h00;
        bit_cycle(cmd, 1'b0);
        for (int i = 6; i >= 0; i--) bit_cycle(a[i], 1'b0);
        for (int k = 0; k < nbits; k++) begin
            bit_cycle(tx_words[k/8][7-(k%8)], 1'b0);
            rx_words[k/8][7-(k%8)] = cipo;
        end
        last_busy = busy;
    endtask

    task automatic end_frame();
        bit_cycle(1'b0, 1'b1);
        bit_cycle(1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        nCS   = 1'b1;
        COPI  = 1'b0;
        bit_cycle(1'b0, 1'b1);
        bit_cycle(1'b0, 1'b1);
        check("rst_regs", regs_flat, 40'h0);
        check("rst_cipo", cipo, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_addr", wr_addr, 7'd0);
        rst_n = 1'b1;
        bit_cycle(1'b0, 1'b1);

        // write 0xA5 to addr 2
        s0 = strobe_total;
        tx_words[0] = 8'hA5;
        frame(1'b1, 7'd2, 8);
        check("wr2_busy_in_frame", last_busy, 1'b1);
        end_frame();
        check("wr2_regs", regs_flat, 40'h00_00_A5_00_00);
        check("wr2_strobes", strobe_total - s0, 1);
        check("wr2_wr_addr", wr_addr, 7'd2);
        check("wr2_busy_after", busy, 1'b0);

        // write 0x3C to addr 4, then read it back
        tx_words[0] = 8'h3C;
        frame(1'b1, 7'd4, 8);
        check("wr4_cipo_quiet", rx_words[0], 8'h00);
        end_frame();
        check("wr4_regs", regs_flat, 40'h3C_00_A5_00_00);
        tx_words[0] = 8'h00;
        frame(1'b0, 7'd4, 8);
        end_frame();
        check("rd4_data", rx_words[0], 8'h3C);
        check("rd4_regs_kept", regs_flat, 40'h3C_00_A5_00_00);

        // burst write from addr 3 wraps to addr 0
        s0 = strobe_total;
        tx_words[0] = 8'h11;
        tx_words[1] = 8'h22;
        tx_words[2] = 8'h33;
        frame(1'b1, 7'd3, 24);
        end_frame();
        check("burst_regs", regs_flat, 40'h22_11_A5_00_33);
        check("burst_strobes", strobe_total - s0, 3);
        check("burst_wr_addr", wr_addr, 7'd0);

        // burst read from addr 3, words back to back across the wrap
        tx_words[0] = 8'h00;
        tx_words[1] = 8'h00;
        tx_words[2] = 8'h00;
        frame(1'b0, 7'd3, 24);
        end_frame();
        check("burst_rd_w0", rx_words[0], 8'h11);
        check("burst_rd_w1", rx_words[1], 8'h22);
        check("burst_rd_w2", rx_words[2], 8'h33);
        check("pre_err_clear", addr_err, 1'b0);

        // out-of-range write and read at addr 9
        s0 = strobe_total;
        tx_words[0] = 8'hFF;
        frame(1'b1, 7'd9, 8);
        end_frame();
        check("oor_wr_regs", regs_flat, 40'h22_11_A5_00_33);
        check("oor_wr_strobes", strobe_total - s0, 0);
        check("oor_wr_err", addr_err, 1'b1);
        check("oor_wr_addr_kept", wr_addr, 7'd0);
        bit_cycle(1'b0, 1'b1);
        bit_cycle(1'b0, 1'b1);
        check("oor_err_sticky", addr_err, 1'b1);
        tx_words[0] = 8'h00;
        frame(1'b0, 7'd9, 8);
        end_frame();
        check("oor_rd_data", rx_words[0], 8'h00);
        check("oor_rd_err", addr_err, 1'b1);

        // write to addr 1 aborted after 5 data bits
        s0 = strobe_total;
        tx_words[0] = 8'hFF;
        frame(1'b1, 7'd1, 5);
        bit_cycle(1'b0, 1'b1);
        check("abort_busy", busy, 1'b0);
        bit_cycle(1'b0, 1'b1);
        check("abort_regs", regs_flat, 40'h22_11_A5_00_33);
        check("abort_strobes", strobe_total - s0, 0);

        // reset in the middle of a read of addr 2 (0xA5)
        tx_words[0] = 8'h00;
        frame(1'b0, 7'd2, 2);
        check("midrd_first_bits", rx_words[0][7:6], 2'b10);
        rst_n = 1'b0;
        bit_cycle(1'b0, 1'b0);
        check("midrst_regs", regs_flat, 40'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err", addr_err, 1'b0);
        check("midrst_strobe", wr_strobe, 1'b0);
        check("midrst_wr_addr", wr_addr, 7'd0);
        @(negedge SCLK);
        #1;
        check("midrst_cipo", cipo, 1'b0);
        rst_n = 1'b1;
        nCS   = 1'b1;
        bit_cycle(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
